// File: rtl/sub_pkg.sv
// sub_pkg: shared constants, FSM encoding and lane zero-flag helper for sub_arbiter
package sub_pkg;
  localparam int SUB_W = 16;
  localparam logic [1:0] LANE4 = 2'b00;
  localparam logic [1:0] LANE8 = 2'b01;
  localparam logic [1:0] LANE16 = 2'b10;
  typedef enum logic {IDLE, HOLD} state_e;
  function automatic logic [3:0] lane_zero(input logic [SUB_W-1:0] d, input logic [1:0] bn);
    return bn == LANE4 ? {d[15:12] == 4'h0, d[11:8] == 4'h0, d[7:4] == 4'h0, d[3:0] == 4'h0} :
           bn == LANE16 ? {3'b000, d == 16'h0000} :
           {2'b00, d[15:8] == 8'h00, d[7:0] == 8'h00};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after ptr_i, wrapping modulo NREQ
//   req_i  in  NREQ  pending requests
//   ptr_i  in  IDW   highest-priority index
//   en_i   in  1     allow a grant this cycle
//   gnt_o  out NREQ  one-hot grant (zero unless en_i and any request)
//   idx_o  out IDW   winner index
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);
  always_comb begin
    idx_o = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % NREQ]) idx_o = IDW'((int'(ptr_i) + k) % NREQ);
    gnt_o = en_i && |req_i ? NREQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/sub.sv
// sub: packed 16-bit subtractor; lanes 4/8/16 bits chosen by bitnum_i, mode 11 treated as 8-bit lanes
//   a_i      in  16  minuend
//   b_i      in  16  subtrahend
//   bitnum_i in  2   lane mode
//   d_o      out 16  per-lane difference, no borrow across lanes
module sub
  import sub_pkg::*;
(
  input  logic [SUB_W-1:0] a_i,
  input  logic [SUB_W-1:0] b_i,
  input  logic [1:0]       bitnum_i,
  output logic [SUB_W-1:0] d_o
);
  logic [SUB_W-1:0] d4, d8, d16;
  always_comb begin
    d4 = {a_i[15:12] - b_i[15:12], a_i[11:8] - b_i[11:8], a_i[7:4] - b_i[7:4], a_i[3:0] - b_i[3:0]};
    d8 = {a_i[15:8] - b_i[15:8], a_i[7:0] - b_i[7:0]};
    d16 = a_i - b_i;
    d_o = bitnum_i == LANE4 ? d4 : bitnum_i == LANE16 ? d16 : d8;
  end
endmodule

// File: rtl/sub_arbiter.sv
// sub_arbiter: round-robin sharing of one packed subtractor among NREQ requesters, registered valid/ready result
//   clk, rst (async, active high)
//   req_i / req_data_a_i / req_data_b_i / req_bitnum_i : per-requester request and operands
//   gnt_o        : one-hot, operands of the winner taken this cycle
//   res_valid_o / res_ready_i : result handshake
//   res_sub_o / res_id_o / res_bitnum_o : registered difference, winner id, lane mode
//   res_zero_o   : per-lane zero flags, present only when SUB_ZERO_FLAG_EN is defined
module sub_arbiter
  import sub_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*SUB_W-1:0] req_data_a_i,
  input  logic [NREQ*SUB_W-1:0] req_data_b_i,
  input  logic [NREQ*2-1:0]     req_bitnum_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [SUB_W-1:0]      res_sub_o,
  output logic [IDW-1:0]        res_id_o,
  output logic [1:0]            res_bitnum_o
`ifdef SUB_ZERO_FLAG_EN
  ,
  output logic [3:0]            res_zero_o
`endif
);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, win, res_id_q;
  logic accept;
  logic [SUB_W-1:0] op_a, op_b, diff, res_sub_q;
  logic [1:0] op_bn, res_bitnum_q;
  // rst gates accept so no grant is issued while the result path is being cleared
  assign accept = |req_i && !rst && (state_q == IDLE || res_ready_i);
  assign op_a = req_data_a_i[win*SUB_W +: SUB_W];
  assign op_b = req_data_b_i[win*SUB_W +: SUB_W];
  assign op_bn = req_bitnum_i[win*2 +: 2];
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .en_i(accept),
    .gnt_o(gnt_o),
    .idx_o(win)
  );
  sub u_sub (
    .a_i(op_a),
    .b_i(op_b),
    .bitnum_i(op_bn),
    .d_o(diff)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  always_comb begin
    state_d = accept ? HOLD : res_ready_i ? IDLE : state_q;
    ptr_d = !accept ? ptr_q : win == IDW'(NREQ - 1) ? '0 : win + 1'b1;
  end
  always_comb begin
    res_valid_o = state_q == HOLD;
    res_sub_o = res_sub_q;
    res_id_o = res_id_q;
    res_bitnum_o = res_bitnum_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sub_q <= '0;
      res_id_q <= '0;
      res_bitnum_q <= '0;
    end else if (accept) begin
      res_sub_q <= diff;
      res_id_q <= win;
      res_bitnum_q <= op_bn;
    end
  end
`ifdef SUB_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_zero_o <= '0;
    else if (accept) res_zero_o <= lane_zero(diff, op_bn);
  end
`endif
endmodule

// File: tb/tb_sub_arbiter.sv
// tb_sub_arbiter: directed scoreboard bench for sub_arbiter with immediate-assertion checks
module tb_sub_arbiter;
  localparam int NREQ = 4;
  typedef struct {
    logic [15:0] sub;
    logic [1:0]  id;
    logic [1:0]  bn;
    logic [3:0]  z;
  } exp_t;
  logic clk = 0, rst = 0;
  logic [NREQ-1:0] req = '0, gnt;
  logic [NREQ*16-1:0] req_a = '0, req_b = '0;
  logic [NREQ*2-1:0] req_bn = '0;
  logic res_valid, res_ready = 0;
  logic [15:0] res_sub;
  logic [1:0] res_id, res_bitnum;
`ifdef SUB_ZERO_FLAG_EN
  logic [3:0] res_zero;
`endif
  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  sub_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req),
    .req_data_a_i(req_a),
    .req_data_b_i(req_b),
    .req_bitnum_i(req_bn),
    .gnt_o(gnt),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_sub_o(res_sub),
    .res_id_o(res_id),
    .res_bitnum_o(res_bitnum)
`ifdef SUB_ZERO_FLAG_EN
    ,
    .res_zero_o(res_zero)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b, input logic [1:0] bn);
    exp_t e;
    int w, m, la, lb, d, r;
    w = bn == 2'b00 ? 4 : bn == 2'b10 ? 16 : 8;
    m = (1 << w) - 1;
    r = 0;
    e.z = '0;
    for (int l = 0; l < 16 / w; l++) begin
      la = (int'(a) >> (l * w)) & m;
      lb = (int'(b) >> (l * w)) & m;
      d = (la + (~lb & m) + 1) & m;
      r = r | (d << (l * w));
      e.z[l] = d == 0;
    end
    e.sub = 16'(r);
    e.id = 2'(id);
    e.bn = bn;
    return e;
  endfunction
  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] bn);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_bn[i*2 +: 2] = bn;
  endtask
  task automatic cycle(input logic [NREQ-1:0] exp_gnt, input string tag);
    @(negedge clk);
    chk({tag, ":gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ":valid"}, 32'(res_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ":sub"}, 32'(res_sub), 32'(q[0].sub));
      chk({tag, ":id"}, 32'(res_id), 32'(q[0].id));
      chk({tag, ":bitnum"}, 32'(res_bitnum), 32'(q[0].bn));
`ifdef SUB_ZERO_FLAG_EN
      chk({tag, ":zero"}, 32'(res_zero), 32'(q[0].z));
`endif
      if (res_ready) void'(q.pop_front());
    end
    for (int i = 0; i < NREQ; i++)
      if (exp_gnt[i]) q.push_back(model(i, req_a[i*16 +: 16], req_b[i*16 +: 16], req_bn[i*2 +: 2]));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 rst = 1;
    req = 4'b1111;
    #3;
    chk("rst:gnt", 32'(gnt), 0);
    chk("rst:valid", 32'(res_valid), 0);
    chk("rst:sub", 32'(res_sub), 0);
    chk("rst:id", 32'(res_id), 0);
    chk("rst:bitnum", 32'(res_bitnum), 0);
`ifdef SUB_ZERO_FLAG_EN
    chk("rst:zero", 32'(res_zero), 0);
`endif
    @(posedge clk);
    #1 rst = 0;
    req = '0;
    cycle('0, "idle");
    set_op(0, 16'h1234, 16'h0111, 2'b10);
    req = 4'b0001;
    res_ready = 1;
    cycle(4'b0001, "t1");
    req = '0;
    cycle('0, "t1r");
    set_op(1, 16'h0000, 16'h1111, 2'b00);
    req = 4'b0010;
    cycle(4'b0010, "t2m00");
    set_op(1, 16'h0000, 16'h1111, 2'b01);
    cycle(4'b0010, "t2m01");
    set_op(1, 16'h0000, 16'h1111, 2'b10);
    cycle(4'b0010, "t2m10");
    set_op(1, 16'h1200, 16'h0034, 2'b11);
    cycle(4'b0010, "t2m11");
    req = '0;
    cycle('0, "t2r");
    set_op(3, 16'hABCD, 16'h1234, 2'b10);
    req = 4'b1000;
    cycle(4'b1000, "t3p");
    set_op(0, 16'h5555, 16'h1111, 2'b00);
    set_op(1, 16'h8000, 16'h0001, 2'b01);
    set_op(2, 16'h0F0F, 16'h0F0F, 2'b10);
    req = 4'b1111;
    cycle(4'b0001, "t3g0");
    cycle(4'b0010, "t3g1");
    cycle(4'b0100, "t3g2");
    cycle(4'b1000, "t3g3");
    cycle(4'b0001, "t3g0b");
    req = '0;
    cycle('0, "t3r");
    req = 4'b0001;
    cycle(4'b0001, "t4a");
    set_op(1, 16'h7777, 16'h0101, 2'b00);
    req = 4'b0010;
    res_ready = 0;
    cycle('0, "t4h1");
    cycle('0, "t4h2");
    cycle('0, "t4h3");
    res_ready = 1;
    cycle(4'b0010, "t4g");
    req = '0;
    res_ready = 0;
    cycle('0, "t4v");
    req = 4'b1010;
    rst = 1;
    #1;
    chk("t5:valid", 32'(res_valid), 0);
    chk("t5:gnt", 32'(gnt), 0);
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    res_ready = 1;
    set_op(1, 16'h0040, 16'h0041, 2'b00);
    cycle(4'b0010, "t5g");
    req = '0;
    cycle('0, "t5r");
    set_op(0, 16'h1234, 16'h1200, 2'b00);
    req = 4'b0001;
    cycle(4'b0001, "t6m00");
    set_op(0, 16'h1234, 16'h1200, 2'b01);
    cycle(4'b0001, "t6m01");
    req = '0;
    cycle('0, "t6r");
    cycle('0, "end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
